decoder_2_4_stream: RTL and testbench

//  Registered 2-to-4 decoder with valid/ready handshakes. Consumer side of the
//  4-to-2 priority encoder stream: takes {y[1:0], v} and regenerates the one-hot line.
//  Has a 2-entry skid buffer for full-throughput back-pressure, plus saturating
//  per-line event counters for debug/statistics.

---
 rtl/decoder_pkg.sv | 36 +++
 rtl/decoder_2_4_stream_fifo2_skid.sv | 51 +++++
 rtl/decoder_2_4_stream.sv | 69 ++++++
 tb/tb_decoder_2_4_stream.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types for the 2-to-4 stream decoder: input code, FIFO entry, one-hot line constants
// and the decode helper used at accept time.
package decoder_pkg;

  typedef struct packed {
    logic [1:0] y;
    logic       v;
  } code_t;

  typedef struct packed {
    logic [3:0] d;
    logic       none;
  } entry_t;

  localparam int         ENTRY_W   = $bits(entry_t);
  localparam logic [1:0] DEPTH     = 2'd2;
  localparam logic [3:0] ONEHOT_L0 = 4'b0001;
  localparam logic [3:0] ONEHOT_L1 = 4'b0010;
  localparam logic [3:0] ONEHOT_L2 = 4'b0100;
  localparam logic [3:0] ONEHOT_L3 = 4'b1000;

  // A v=0 code carries no line; it becomes an all-zero word flagged with none.
  function automatic entry_t decode(input code_t c);
    entry_t e;
    e.none = ~c.v;
    unique case (c.y)
      2'd0:    e.d = ONEHOT_L0;
      2'd1:    e.d = ONEHOT_L1;
      2'd2:    e.d = ONEHOT_L2;
      default: e.d = ONEHOT_L3;
    endcase
    if (!c.v) e.d = 4'b0000;
    return e;
  endfunction

endpackage

// File: rtl/decoder_2_4_stream_fifo2_skid.sv
// Two-entry skid FIFO, head held in a register; 1-cycle latency, full rate.
// wr_rdy depends only on occupancy (< 2), never on rd_rdy.
module fifo2_skid
  import decoder_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_vld,
  output logic               wr_rdy,
  input  logic [ENTRY_W-1:0] wr_dat,
  output logic               rd_vld,
  input  logic               rd_rdy,
  output logic [ENTRY_W-1:0] rd_dat
);

  logic [1:0]         occ;
  logic [ENTRY_W-1:0] head_q;
  logic [ENTRY_W-1:0] tail_q;
  logic               push;
  logic               pop;

  assign wr_rdy = (occ < DEPTH);
  assign rd_vld = (occ != 2'd0);
  assign rd_dat = head_q;
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_vld && rd_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ    <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head_q <= wr_dat;
          else             tail_q <= wr_dat;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == DEPTH) head_q <= tail_q;
          occ <= occ - 2'd1;
        end
        // Push with pop only happens at occupancy 1: the new word replaces the head.
        2'b11:   head_q <= wr_dat;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/decoder_2_4_stream.sv
// Registered 2-to-4 stream decoder with per-line saturating counters; code accepted at edge t
// appears on out_d after edge t. Two-entry skid buffer, in_ready = occupancy < 2.
module decoder_2_4_stream
  import decoder_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter bit DROP_INVALID = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_y,
  input  logic               in_v,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_d,
  output logic               out_none,
  input  logic               cnt_clr,
  output logic [4*CNT_W-1:0] hit_cnt,
  output logic [3:0]         hit_sat
);

  code_t             in_code;
  entry_t            in_ent;
  entry_t            head;
  logic [ENTRY_W-1:0] head_raw;
  logic              keep;
  logic              pop;
  logic [CNT_W-1:0]  cnt_q [4];

  assign in_code = '{y: in_y, v: in_v};
  assign in_ent  = decode(in_code);
  // Dropped codes still complete the input handshake; they just never reach the FIFO.
  assign keep    = in_v || !DROP_INVALID;

  fifo2_skid u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (in_valid && keep),
    .wr_rdy (in_ready),
    .wr_dat (in_ent),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (head_raw)
  );

  assign head     = entry_t'(head_raw);
  assign out_d    = head.d;
  assign out_none = head.none;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (pop) begin
      for (int i = 0; i < 4; i++)
        if (out_d[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign hit_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    assign hit_sat[g]                = (cnt_q[g] == '1);
  end

endmodule

// File: tb/tb_decoder_2_4_stream.sv
// Directed and random stimulus for decoder_2_4_stream checked against a queue-based model.
module tb_decoder_2_4_stream;

  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    int y;
    bit v;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_v, out_valid, out_ready, out_none, cnt_clr;
  logic [1:0]    in_y;
  logic [3:0]    out_d, hit_sat;
  logic [4*CW-1:0] hit_cnt;

  logic          d2_in_valid, d2_in_ready, d2_in_v, d2_out_valid, d2_out_ready, d2_out_none, d2_cnt_clr;
  logic [1:0]    d2_in_y;
  logic [3:0]    d2_out_d, d2_hit_sat;
  logic [4*CW-1:0] d2_hit_cnt;

  int    tests = 0;
  int    fails = 0;
  word_t q[$];
  int    exp_cnt[4];

  always #5 clk = ~clk;

  decoder_2_4_stream #(.CNT_W(CW), .DROP_INVALID(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_v(in_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_none(out_none),
    .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .hit_sat(hit_sat)
  );

  decoder_2_4_stream #(.CNT_W(CW), .DROP_INVALID(1'b1)) dut_drop (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_y(d2_in_y),
    .in_v(d2_in_v), .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_d(d2_out_d),
    .out_none(d2_out_none), .cnt_clr(d2_cnt_clr), .hit_cnt(d2_hit_cnt), .hit_sat(d2_hit_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [3:0] sat;
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_d", 32'(out_d), q[0].v ? (32'd1 << q[0].y) : 32'd0);
      chk("out_none", 32'(out_none), 32'(!q[0].v));
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hit_cnt%0d", i), 32'(hit_cnt[i*CW +: CW]), exp_cnt[i]);
      sat[i] = (exp_cnt[i] == CMAX);
    end
    chk("hit_sat", 32'(hit_sat), 32'(sat));
  endtask

  task automatic update_model();
    bit    acc;
    bit    pop;
    word_t w;
    acc = in_valid && (q.size() < 2);
    pop = (q.size() != 0) && out_ready;
    if (pop) begin
      w = q.pop_front();
      if (w.v && exp_cnt[w.y] < CMAX) exp_cnt[w.y]++;
    end
    if (cnt_clr) for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    if (acc) q.push_back('{y: int'(in_y), v: in_v});
  endtask

  // Check the state left by the previous edge, then advance the model and the DUT by one edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input int y, input logic v, input logic rdy);
    in_valid  = vld;
    in_y      = 2'(y);
    in_v      = v;
    out_ready = rdy;
  endtask

  initial begin
    rst_n = 1'b0; cnt_clr = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0);
    d2_in_valid = 1'b0; d2_in_y = 2'd0; d2_in_v = 1'b0; d2_out_ready = 1'b1; d2_cnt_clr = 1'b0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_d", 32'(out_d), 0);
    chk("rst_hit_cnt", 32'(hit_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    cycle();

    // Decode sweep at full rate.
    for (int y = 0; y < 4; y++) begin drive(1'b1, y, 1'b1, 1'b1); cycle(); end
    drive(1'b0, 0, 1'b0, 1'b1); cycle(); cycle();
    for (int i = 0; i < 4; i++) chk($sformatf("sweep_cnt%0d", i), 32'(hit_cnt[i*CW +: CW]), 1);

    // Invalid code is forwarded as an all-zero word.
    drive(1'b1, 2, 1'b0, 1'b1); cycle();
    drive(1'b0, 0, 1'b0, 1'b1); cycle(); cycle();

    // The dropping instance consumes v=0 but forwards v=1.
    d2_in_valid = 1'b1; d2_in_y = 2'd2; d2_in_v = 1'b0;
    @(negedge clk); chk("drop_in_ready", 32'(d2_in_ready), 1);
    @(posedge clk); #1; d2_in_valid = 1'b0;
    chk("drop_out_valid", 32'(d2_out_valid), 0);
    @(posedge clk); #1;
    chk("drop_out_valid2", 32'(d2_out_valid), 0);
    d2_in_valid = 1'b1; d2_in_y = 2'd3; d2_in_v = 1'b1;
    @(posedge clk); #1; d2_in_valid = 1'b0;
    chk("drop_fwd_valid", 32'(d2_out_valid), 1);
    chk("drop_fwd_d", 32'(d2_out_d), 32'h8);

    // Back-pressure: third code is held until space frees up.
    drive(1'b1, 3, 1'b1, 1'b0); cycle();
    drive(1'b1, 1, 1'b1, 1'b0); cycle();
    drive(1'b1, 2, 1'b0, 1'b0); cycle(); cycle();
    chk("bp_in_ready", 32'(in_ready), 0);
    drive(1'b1, 2, 1'b0, 1'b1); cycle();
    drive(1'b0, 0, 1'b0, 1'b1); cycle(); cycle(); cycle();

    // Simultaneous push/pop keeps occupancy at 1.
    for (int k = 0; k < 11; k++) begin drive(1'b1, k % 4, 1'b1, 1'b1); cycle(); end
    chk("pp_valid", 32'(out_valid), 1);
    chk("pp_ready", 32'(in_ready), 1);
    drive(1'b0, 0, 1'b0, 1'b1); cycle(); cycle();

    // Saturation, then clear racing a pop.
    cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
    for (int k = 0; k < 10; k++) begin drive(1'b1, 1, 1'b1, 1'b1); cycle(); end
    drive(1'b0, 0, 1'b0, 1'b1); cycle(); cycle();
    chk("sat_cnt1", 32'(hit_cnt[CW +: CW]), 7);
    chk("sat_flags", 32'(hit_sat), 32'b0010);
    drive(1'b1, 1, 1'b1, 1'b0); cycle();
    drive(1'b0, 0, 1'b0, 1'b1); cnt_clr = 1'b1; cycle();
    cnt_clr = 1'b0;
    chk("clr_pop_cnt1", 32'(hit_cnt[CW +: CW]), 0);
    cycle();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      drive(1'(($urandom_range(0, 3) != 0)), $urandom_range(0, 3), 1'(($urandom_range(0, 4) != 0)),
            1'(($urandom_range(0, 2) != 0)));
      cnt_clr = ($urandom_range(0, 63) == 0);
      cycle();
    end
    cnt_clr = 1'b0;

    // Reset mid-stream with two entries held.
    drive(1'b1, 0, 1'b1, 1'b0); cycle(); cycle(); cycle();
    drive(1'b0, 0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_d", 32'(out_d), 0);
    chk("arst_hit_cnt", 32'(hit_cnt), 0);
    chk("arst_hit_sat", 32'(hit_sat), 0);
    q.delete();
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle();
    drive(1'b1, 2, 1'b1, 1'b1); cycle();
    drive(1'b0, 0, 1'b0, 1'b1); cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
